bullet_manager: RTL and testbench
=================================

# bullet_manager

Owns the 8-slot bullet pool for the tank game: accepts fire requests from both players, spawns bullets in front of the firing tank, advances them each game tick, and retires them at the map edge or when the collision stage flags them. Sits directly upstream of the collision stage: drives its `bullet_active`/`bullet_x*`/`bullet_y*`/`bullet_owner` inputs and consumes its registered `bullet_destroy` output as feedback.

## Interface
- `MAP_W`, 160, playfield width in cells; legal bullet x is 0..MAP_W-2
- `MAP_H`, 120, playfield height in cells; legal bullet y is 0..MAP_H-2
- `SPEED`, 1, cells moved per tick (1..7)
- `COOLDOWN`, 8, ticks between accepted shots per player (1..255)
- `clk` in 1 system clock; all state on rising edge
- `rstn` in 1 asynchronous, active-low reset
- `tick` in 1 one-cycle game-tick strobe; enables movement and cooldown decrement
- `p1_fire`, `p2_fire` in 1 level fire requests
- `p1_alive`, `p2_alive` in 1 dead player's fire is ignored
- `p1_x`, `p1_y`, `p2_x`, `p2_y` in 8 each tank top-left (tank is 3 wide, 4 tall)
- `p1_dir`, `p2_dir` in 2 each facing: 0 up, 1 right, 2 down, 3 left
- `bullet_destroy` in 8 per-slot kill from collision stage
- `bullet_active` out 8 slot occupied
- `bullet_x0`..`bullet_x7`, `bullet_y0`..`bullet_y7` out 8 each bullet top-left (bullet is 2x2)
- `bullet_owner` out 8 0 = P1 bullet, 1 = P2 bullet

## Operation
- Per slot: active, x, y, dir[1:0], owner registers; all outputs driven directly from registers.
- Spawn position from tank (x,y): up (x, y-2); down (x, y+4); left (x-2, y+1); right (x+3, y+1). Spawn legal only if resulting x in 0..MAP_W-2 and y in 0..MAP_H-2 with no 8-bit underflow; otherwise request rejected, no cooldown load.
- Player request accepted when fire=1, alive=1, cooldown=0, spawn legal, free slot exists. Free slot = active=0 at cycle start.
- Allocation: lowest free index. Both accept same cycle: P1 takes lowest free, P2 next lowest; if only one free, P1 wins, P2 not accepted (cooldown unchanged, retries next cycle).
- On accept: slot loaded active=1, position, dir=player dir, owner; player cooldown := COOLDOWN.
- Cooldown: on tick, decrement if nonzero, saturate at 0. Accept in a tick cycle loads COOLDOWN (load wins).
- Movement on tick for each active slot not destroyed and not spawned this cycle: step SPEED in dir. If step would leave legal range (up: y<SPEED; left: x<SPEED; down: y+SPEED>MAP_H-2; right: x+SPEED>MAP_W-2) slot clears active instead; x/y hold last value. Arithmetic in 9 bits, compare before truncation.
- bullet_destroy[i]=1: clears active[i] that cycle; overrides movement. Destroy on inactive slot ignored. A slot freed this cycle is not allocatable until next cycle.

## Timing
- Reset (async assert, sync release by caller): bullet_active=0, all x/y=0, bullet_owner=0, dirs=0, both cooldowns=0.
- Fire sampled at edge N -> bullet visible on outputs after edge N (1-cycle latency).
- Movement/retire takes effect at the tick edge; outputs update same edge.
- Collision feedback arrives 1 cycle after position; destroy at edge N+1 retires a bullet hit at position from edge N; a tick at N+1 does not move it.
- Reset mid-flight clears all slots immediately; no pending state survives.

## Configuration
- `BULLET_PER_PLAYER_LIMIT_EN` defined: a player owning 4 active bullets has requests rejected (cooldown unchanged) even if free slots exist. Undefined: shared pool only, one player may occupy all 8 slots.

## Test plan
- Reset, p1 at (10,20) dir=1, p1_fire 1 cycle -> next cycle slot0 active, (13,21), owner=0, cooldown=8.
- P1 and P2 fire same cycle, pool empty -> slot0 owner 0, slot1 owner 1; with slots 0-6 full -> only slot7 filled, by P1; P2 fires next cycle once its conditions hold.
- Bullet at x=157 dir=right, SPEED=1, tick -> x=158; next tick -> active clears, x stays 158; up-facing tank at y=1 fire -> rejected, cooldown stays 0.
- bullet_destroy=8'b0000_0100 together with tick -> slot2 inactive, slot2 not moved; other slots move; slot2 unavailable to fire in that cycle, used next cycle.
- Hold p1_fire with 8 ticks spaced apart -> exactly one accepted shot per 8 ticks; p1_alive=0 -> no shots.
- With `BULLET_PER_PLAYER_LIMIT_EN`, P1 fires 5 times (cooldown satisfied) -> 4 active, 5th rejected; without macro -> 5 active.

Source files
------------

// File: rtl/bullet_manager.sv
// bullet_manager: owns the 8-slot bullet pool for the tank game.
// Accepts fire requests from both players, spawns bullets in front of the
// firing tank, moves them on each game tick and retires them at the map edge
// or when the downstream collision stage asserts bullet_destroy.
// Optional build macro: BULLET_PER_PLAYER_LIMIT_EN caps each player at four
// live bullets; when it is undefined one player may occupy the whole pool.
module bullet_manager #(
    parameter int MAP_W    = 160,
    parameter int MAP_H    = 120,
    parameter int SPEED    = 1,
    parameter int COOLDOWN = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tick,
    input  logic       p1_fire,
    input  logic       p2_fire,
    input  logic       p1_alive,
    input  logic       p2_alive,
    input  logic [7:0] p1_x,
    input  logic [7:0] p1_y,
    input  logic [7:0] p2_x,
    input  logic [7:0] p2_y,
    input  logic [1:0] p1_dir,
    input  logic [1:0] p2_dir,
    input  logic [7:0] bullet_destroy,
    output logic [7:0] bullet_active,
    output logic [7:0] bullet_x0,
    output logic [7:0] bullet_x1,
    output logic [7:0] bullet_x2,
    output logic [7:0] bullet_x3,
    output logic [7:0] bullet_x4,
    output logic [7:0] bullet_x5,
    output logic [7:0] bullet_x6,
    output logic [7:0] bullet_x7,
    output logic [7:0] bullet_y0,
    output logic [7:0] bullet_y1,
    output logic [7:0] bullet_y2,
    output logic [7:0] bullet_y3,
    output logic [7:0] bullet_y4,
    output logic [7:0] bullet_y5,
    output logic [7:0] bullet_y6,
    output logic [7:0] bullet_y7,
    output logic [7:0] bullet_owner
);

    // Spawn legality uses 10-bit signed math so an 8-bit underflow shows up as negative.
    localparam logic signed [9:0] SPAWN_X_MAX = 10'(MAP_W - 2);
    localparam logic signed [9:0] SPAWN_Y_MAX = 10'(MAP_H - 2);
    // Movement uses 9-bit math so the edge compare happens before truncation.
    localparam logic [8:0] MOVE_X_MAX = 9'(MAP_W - 2);
    localparam logic [8:0] MOVE_Y_MAX = 9'(MAP_H - 2);
    localparam logic [8:0] STEP       = 9'(SPEED);
    localparam logic [7:0] CD_LOAD    = 8'(COOLDOWN);

    logic [7:0] active_q;
    logic [7:0] owner_q;
    logic [7:0] pos_x [8];
    logic [7:0] pos_y [8];
    logic [1:0] dir_q [8];
    logic [7:0] cd1;
    logic [7:0] cd2;

    logic [16:0] spawn1;
    logic [16:0] spawn2;
    logic [16:0] step_res [8];
    logic        req1;
    logic        req2;
    logic        have1;
    logic        have2;
    logic        acc1;
    logic        acc2;
    logic [2:0]  slot1;
    logic [2:0]  slot2;
    logic [7:0]  free2;
    logic        lim1;
    logic        lim2;

    // Returns {legal, x, y} for a bullet spawned in front of a tank at (tx,ty).
    function automatic logic [16:0] spawn_at(input logic [7:0] tx, input logic [7:0] ty,
                                             input logic [1:0] d);
        logic signed [9:0] sx;
        logic signed [9:0] sy;
        logic              ok;
        sx = $signed({2'b00, tx});
        sy = $signed({2'b00, ty});
        case (d)
            2'd0:    sy = sy - 10'sd2;
            2'd1:    begin sx = sx + 10'sd3; sy = sy + 10'sd1; end
            2'd2:    sy = sy + 10'sd4;
            default: begin sx = sx - 10'sd2; sy = sy + 10'sd1; end
        endcase
        ok = (sx >= 10'sd0) && (sx <= SPAWN_X_MAX) && (sy >= 10'sd0) && (sy <= SPAWN_Y_MAX);
        return {ok, sx[7:0], sy[7:0]};
    endfunction

    // Returns {stays_on_map, x, y} after one movement step in direction d.
    function automatic logic [16:0] step_from(input logic [7:0] bx, input logic [7:0] by,
                                              input logic [1:0] d);
        logic [8:0] nx;
        logic [8:0] ny;
        logic       keep;
        nx   = {1'b0, bx};
        ny   = {1'b0, by};
        keep = 1'b1;
        case (d)
            2'd0: begin
                if (ny < STEP) keep = 1'b0;
                else           ny   = ny - STEP;
            end
            2'd1: begin
                nx   = nx + STEP;
                keep = (nx <= MOVE_X_MAX);
            end
            2'd2: begin
                ny   = ny + STEP;
                keep = (ny <= MOVE_Y_MAX);
            end
            default: begin
                if (nx < STEP) keep = 1'b0;
                else           nx   = nx - STEP;
            end
        endcase
        return {keep, nx[7:0], ny[7:0]};
    endfunction

`ifdef BULLET_PER_PLAYER_LIMIT_EN
    logic [3:0] owned1;
    logic [3:0] owned2;

    // Count live bullets per player so a player holding four is refused.
    always_comb begin
        owned1 = '0;
        owned2 = '0;
        for (int i = 0; i < 8; i++) begin
            owned1 = owned1 + {3'b000, active_q[i] & ~owner_q[i]};
            owned2 = owned2 + {3'b000, active_q[i] &  owner_q[i]};
        end
        lim1 = (owned1 >= 4'd4);
        lim2 = (owned2 >= 4'd4);
    end
`else
    assign lim1 = 1'b0;
    assign lim2 = 1'b0;
`endif

    // Decide which requests are accepted and which slots they land in; P1 gets priority.
    always_comb begin
        spawn1 = spawn_at(p1_x, p1_y, p1_dir);
        spawn2 = spawn_at(p2_x, p2_y, p2_dir);
        req1   = p1_fire & p1_alive & (cd1 == 8'd0) & spawn1[16] & ~lim1;
        req2   = p2_fire & p2_alive & (cd2 == 8'd0) & spawn2[16] & ~lim2;
        have1  = 1'b0;
        slot1  = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!active_q[i]) begin
                have1 = 1'b1;
                slot1 = 3'(i);
            end
        end
        acc1  = req1 & have1;
        free2 = ~active_q;
        if (acc1) free2[slot1] = 1'b0;
        have2 = 1'b0;
        slot2 = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (free2[i]) begin
                have2 = 1'b1;
                slot2 = 3'(i);
            end
        end
        acc2 = req2 & have2;
        for (int i = 0; i < 8; i++) begin
            step_res[i] = step_from(pos_x[i], pos_y[i], dir_q[i]);
        end
    end

    // Slot state: spawn into free slots, otherwise destroy beats movement on live slots.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            active_q <= '0;
            owner_q  <= '0;
            for (int i = 0; i < 8; i++) begin
                pos_x[i] <= '0;
                pos_y[i] <= '0;
                dir_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (acc1 && slot1 == 3'(i)) begin
                    active_q[i] <= 1'b1;
                    pos_x[i]    <= spawn1[15:8];
                    pos_y[i]    <= spawn1[7:0];
                    dir_q[i]    <= p1_dir;
                    owner_q[i]  <= 1'b0;
                end else if (acc2 && slot2 == 3'(i)) begin
                    active_q[i] <= 1'b1;
                    pos_x[i]    <= spawn2[15:8];
                    pos_y[i]    <= spawn2[7:0];
                    dir_q[i]    <= p2_dir;
                    owner_q[i]  <= 1'b1;
                end else if (active_q[i]) begin
                    if (bullet_destroy[i]) begin
                        active_q[i] <= 1'b0;
                    end else if (tick) begin
                        if (step_res[i][16]) begin
                            pos_x[i] <= step_res[i][15:8];
                            pos_y[i] <= step_res[i][7:0];
                        end else begin
                            active_q[i] <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Per-player cooldown: an accepted shot reloads it, otherwise ticks count it down to zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cd1 <= '0;
            cd2 <= '0;
        end else begin
            if (acc1)                   cd1 <= CD_LOAD;
            else if (tick && cd1 != 0)  cd1 <= cd1 - 8'd1;
            if (acc2)                   cd2 <= CD_LOAD;
            else if (tick && cd2 != 0)  cd2 <= cd2 - 8'd1;
        end
    end

    assign bullet_active = active_q;
    assign bullet_owner  = owner_q;
    assign bullet_x0 = pos_x[0];
    assign bullet_x1 = pos_x[1];
    assign bullet_x2 = pos_x[2];
    assign bullet_x3 = pos_x[3];
    assign bullet_x4 = pos_x[4];
    assign bullet_x5 = pos_x[5];
    assign bullet_x6 = pos_x[6];
    assign bullet_x7 = pos_x[7];
    assign bullet_y0 = pos_y[0];
    assign bullet_y1 = pos_y[1];
    assign bullet_y2 = pos_y[2];
    assign bullet_y3 = pos_y[3];
    assign bullet_y4 = pos_y[4];
    assign bullet_y5 = pos_y[5];
    assign bullet_y6 = pos_y[6];
    assign bullet_y7 = pos_y[7];

endmodule

// File: tb/tb_bullet_manager.sv
// tb_bullet_manager: directed scenarios plus randomized traffic for bullet_manager,
// checked every cycle against a slot-list reference model of the bullet pool.
module tb_bullet_manager;

    localparam int MAP_W    = 160;
    localparam int MAP_H    = 120;
    localparam int SPEED    = 1;
    localparam int COOLDOWN = 8;
`ifdef BULLET_PER_PLAYER_LIMIT_EN
    localparam int FIVE_SHOT_COUNT = 4;
`else
    localparam int FIVE_SHOT_COUNT = 5;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       tick = 1'b0;
    logic       p1_fire = 1'b0;
    logic       p2_fire = 1'b0;
    logic       p1_alive = 1'b1;
    logic       p2_alive = 1'b1;
    logic [7:0] p1_x = '0;
    logic [7:0] p1_y = '0;
    logic [7:0] p2_x = '0;
    logic [7:0] p2_y = '0;
    logic [1:0] p1_dir = '0;
    logic [1:0] p2_dir = '0;
    logic [7:0] bullet_destroy = '0;
    logic [7:0] bullet_active;
    logic [7:0] bullet_x0, bullet_x1, bullet_x2, bullet_x3;
    logic [7:0] bullet_x4, bullet_x5, bullet_x6, bullet_x7;
    logic [7:0] bullet_y0, bullet_y1, bullet_y2, bullet_y3;
    logic [7:0] bullet_y4, bullet_y5, bullet_y6, bullet_y7;
    logic [7:0] bullet_owner;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit act;
        int x;
        int y;
        int d;
        bit own;
    } blt_t;

    blt_t mb[8];
    int   mcd[2];

    bullet_manager #(.MAP_W(MAP_W), .MAP_H(MAP_H), .SPEED(SPEED), .COOLDOWN(COOLDOWN)) dut (
        .clk(clk), .rstn(rstn), .tick(tick),
        .p1_fire(p1_fire), .p2_fire(p2_fire), .p1_alive(p1_alive), .p2_alive(p2_alive),
        .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
        .p1_dir(p1_dir), .p2_dir(p2_dir), .bullet_destroy(bullet_destroy),
        .bullet_active(bullet_active),
        .bullet_x0(bullet_x0), .bullet_x1(bullet_x1), .bullet_x2(bullet_x2), .bullet_x3(bullet_x3),
        .bullet_x4(bullet_x4), .bullet_x5(bullet_x5), .bullet_x6(bullet_x6), .bullet_x7(bullet_x7),
        .bullet_y0(bullet_y0), .bullet_y1(bullet_y1), .bullet_y2(bullet_y2), .bullet_y3(bullet_y3),
        .bullet_y4(bullet_y4), .bullet_y5(bullet_y5), .bullet_y6(bullet_y6), .bullet_y7(bullet_y7),
        .bullet_owner(bullet_owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mb[i].act = 0; mb[i].x = 0; mb[i].y = 0; mb[i].d = 0; mb[i].own = 0;
        end
        mcd[0] = 0;
        mcd[1] = 0;
    endtask

    // One clock of pool behaviour derived from the game rules, using the inputs now applied.
    task automatic model_step();
        int tx[2], ty[2], td[2];
        bit fr[2], al[2];
        int sx, sy, nx, ny, owned;
        bit ok;
        int slot[2], px[2], py[2];
        int freeq[$];
        tx[0] = int'(p1_x); ty[0] = int'(p1_y); td[0] = int'(p1_dir); fr[0] = p1_fire; al[0] = p1_alive;
        tx[1] = int'(p2_x); ty[1] = int'(p2_y); td[1] = int'(p2_dir); fr[1] = p2_fire; al[1] = p2_alive;
        for (int i = 0; i < 8; i++) if (!mb[i].act) freeq.push_back(i);
        for (int p = 0; p < 2; p++) begin
            slot[p] = -1;
            sx = tx[p]; sy = ty[p];
            case (td[p])
                0: sy = ty[p] - 2;
                1: begin sx = tx[p] + 3; sy = ty[p] + 1; end
                2: sy = ty[p] + 4;
                default: begin sx = tx[p] - 2; sy = ty[p] + 1; end
            endcase
            ok = fr[p] && al[p] && mcd[p] == 0 && sx >= 0 && sx <= MAP_W - 2 && sy >= 0 && sy <= MAP_H - 2;
            owned = 0;
            for (int i = 0; i < 8; i++) if (mb[i].act && mb[i].own == bit'(p)) owned++;
`ifdef BULLET_PER_PLAYER_LIMIT_EN
            if (owned >= 4) ok = 0;
`endif
            if (ok && freeq.size() > 0) begin
                slot[p] = freeq.pop_front();
                px[p] = sx;
                py[p] = sy;
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (mb[i].act) begin
                if (bullet_destroy[i]) mb[i].act = 0;
                else if (tick) begin
                    nx = mb[i].x + SPEED * ((mb[i].d == 1) ? 1 : (mb[i].d == 3) ? -1 : 0);
                    ny = mb[i].y + SPEED * ((mb[i].d == 2) ? 1 : (mb[i].d == 0) ? -1 : 0);
                    if (nx < 0 || nx > MAP_W - 2 || ny < 0 || ny > MAP_H - 2) mb[i].act = 0;
                    else begin mb[i].x = nx; mb[i].y = ny; end
                end
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (slot[p] >= 0) begin
                mb[slot[p]].act = 1; mb[slot[p]].x = px[p]; mb[slot[p]].y = py[p];
                mb[slot[p]].d = td[p]; mb[slot[p]].own = bit'(p);
                mcd[p] = COOLDOWN;
            end else if (tick && mcd[p] > 0) begin
                mcd[p]--;
            end
        end
    endtask

    task automatic compare_all();
        logic [7:0]  ea, eo;
        logic [63:0] ex, ey, gx, gy;
        for (int i = 0; i < 8; i++) begin
            ea[i] = mb[i].act;
            eo[i] = mb[i].own;
            ex[i*8 +: 8] = 8'(mb[i].x);
            ey[i*8 +: 8] = 8'(mb[i].y);
        end
        gx = {bullet_x7, bullet_x6, bullet_x5, bullet_x4, bullet_x3, bullet_x2, bullet_x1, bullet_x0};
        gy = {bullet_y7, bullet_y6, bullet_y5, bullet_y4, bullet_y3, bullet_y2, bullet_y1, bullet_y0};
        check("active", 64'(bullet_active), 64'(ea));
        check("owner", 64'(bullet_owner), 64'(eo));
        check("xpos", gx, ex);
        check("ypos", gy, ey);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        p1_fire = 0; p2_fire = 0; tick = 0; bullet_destroy = '0;
        rstn = 0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rstn = 1;
    endtask

    task automatic fire_round(input bit f1, input bit f2);
        p1_fire = f1; p2_fire = f2;
        cycle();
        p1_fire = 0; p2_fire = 0;
        tick = 1;
        repeat (8) cycle();
        tick = 0;
    endtask

    function automatic logic [7:0] rand_coord(input int hi);
        case ($urandom_range(0, 3))
            0: return 8'($urandom_range(0, 255));
            1: return 8'($urandom_range(0, 5));
            2: return 8'($urandom_range(hi - 10, hi + 2));
            default: return 8'($urandom_range(0, hi));
        endcase
    endfunction

    initial begin
        model_reset();
        do_reset();

        // first shot: right-facing tank at (10,20), then cooldown holds for 8 ticks
        p1_x = 10; p1_y = 20; p1_dir = 1; p1_fire = 1;
        cycle();
        check("first_active", 64'(bullet_active), 64'h01);
        check("first_x", 64'(bullet_x0), 64'd13);
        check("first_y", 64'(bullet_y0), 64'd21);
        check("first_owner", 64'(bullet_owner), 64'h00);
        tick = 1;
        repeat (8) cycle();
        check("cooldown_hold", 64'($countones(bullet_active)), 64'd1);
        tick = 0;
        cycle();
        check("cooldown_expire", 64'($countones(bullet_active)), 64'd2);
        p1_fire = 0;

        // simultaneous fire, then fill slots 0-6 and contend for the last slot
        do_reset();
        p1_x = 50; p1_y = 100; p1_dir = 0;
        p2_x = 80; p2_y = 100; p2_dir = 0;
        p1_fire = 1; p2_fire = 1;
        cycle();
        check("pair_active", 64'(bullet_active), 64'h03);
        check("pair_owner", 64'(bullet_owner), 64'h02);
        p1_fire = 0; p2_fire = 0; tick = 1;
        repeat (8) cycle();
        tick = 0;
        fire_round(1, 1);
        fire_round(1, 1);
        fire_round(0, 1);
        p1_fire = 1; p2_fire = 1;
        cycle();
        check("last_slot_active", 64'(bullet_active), 64'hFF);
        check("last_slot_owner", 64'(bullet_owner), 64'h6A);
        p1_fire = 0; tick = 1; bullet_destroy = 8'h08;
        cycle();
        check("destroy_active", 64'(bullet_active), 64'hF7);
        tick = 0; bullet_destroy = '0;
        cycle();
        check("refill_active", 64'(bullet_active), 64'hFF);
        check("refill_y3", 64'(bullet_y3), 64'd98);
        p2_fire = 0;

        // right edge retire and illegal upward spawn
        do_reset();
        p1_x = 154; p1_y = 50; p1_dir = 1; p1_fire = 1;
        cycle();
        p1_fire = 0;
        check("edge_spawn_x", 64'(bullet_x0), 64'd157);
        tick = 1;
        cycle();
        check("edge_step_x", 64'(bullet_x0), 64'd158);
        cycle();
        check("edge_retire_active", 64'(bullet_active), 64'h00);
        check("edge_retire_x", 64'(bullet_x0), 64'd158);
        tick = 0;
        p2_x = 20; p2_y = 1; p2_dir = 0; p2_fire = 1;
        cycle();
        check("up_reject", 64'(bullet_active), 64'h00);
        p2_y = 10;
        cycle();
        check("up_after_reject", 64'(bullet_active), 64'h01);
        check("up_after_reject_y", 64'(bullet_y0), 64'd8);
        p2_fire = 0;

        // dead player never fires; live player held on fire with spaced ticks
        do_reset();
        p1_alive = 0; p1_x = 10; p1_y = 60; p1_dir = 1; p1_fire = 1;
        for (int i = 0; i < 20; i++) begin
            tick = bit'(i % 2);
            cycle();
        end
        check("dead_no_shots", 64'(bullet_active), 64'h00);
        p1_alive = 1;
        for (int i = 0; i < 64; i++) begin
            tick = bit'(i % 2);
            cycle();
        end
        p1_fire = 0; tick = 0;

        // five shots from one player, cooldown satisfied between them
        do_reset();
        p1_x = 50; p1_y = 100; p1_dir = 0;
        repeat (5) fire_round(1, 0);
        check("five_shots", 64'($countones(bullet_active)), 64'(FIVE_SHOT_COUNT));

        // randomized traffic with one asynchronous reset mid-flight
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            p1_x = rand_coord(MAP_W); p1_y = rand_coord(MAP_H);
            p2_x = rand_coord(MAP_W); p2_y = rand_coord(MAP_H);
            p1_dir = 2'($urandom_range(0, 3)); p2_dir = 2'($urandom_range(0, 3));
            p1_fire = ($urandom_range(0, 1) == 1); p2_fire = ($urandom_range(0, 1) == 1);
            p1_alive = ($urandom_range(0, 9) != 0); p2_alive = ($urandom_range(0, 9) != 0);
            tick = ($urandom_range(0, 1) == 1);
            for (int b = 0; b < 8; b++) bullet_destroy[b] = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
